// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit adder: the carry chain is cut into STAGES registered slices
// with valid/ready backpressure; reports unsigned carry-out and signed overflow.
module adder_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             aresetn_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   input  logic             Cin_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] S_o,
   output logic             Cout_o,
   output logic             ovf_o
);

   localparam int CW = WIDTH / STAGES;
   localparam int L  = STAGES - 1;

   logic en;
   logic ovf_q, ovf_d;

   // The whole pipe advances or holds as one; bubbles are never squeezed out.
   assign en      = ready_i || !valid_o;
   assign ready_o = en;

   for (genvar g = 0; g < STAGES; g++) begin : st
      localparam int LO = g * CW;
      localparam int HI = LO + CW - 1;

      // Operand bits from this slice upward; lower bits were consumed earlier.
      logic              v_in, c_in;
      logic [WIDTH-1:LO] a_in, b_in;
      logic [CW:0]       sum;
      logic              v_q, v_d, c_q, c_d;
      logic [HI:0]       s_q, s_d;

      if (g == 0) begin : g_src
         assign v_in = valid_i;
         assign c_in = Cin_i;
         assign a_in = A_i;
         assign b_in = B_i;
      end else begin : g_fwd
         assign v_in = st[g-1].v_q;
         assign c_in = st[g-1].c_q;
         assign a_in = st[g-1].g_skew.a_q;
         assign b_in = st[g-1].g_skew.b_q;
      end

      always_comb begin
         sum = {1'b0, a_in[HI:LO]} + {1'b0, b_in[HI:LO]} + {{CW{1'b0}}, c_in};
         v_d = v_in;
         c_d = sum[CW];
      end

      if (g == 0) begin : g_s0
         always_comb s_d = sum[CW-1:0];
      end else begin : g_sn
         always_comb s_d = {sum[CW-1:0], st[g-1].s_q};
      end

      always_ff @(posedge clk_i or negedge aresetn_i) begin
         if (!aresetn_i) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (en) begin
            v_q <= v_d;
            c_q <= c_d;
            s_q <= s_d;
         end
      end

      // Upper operand slices ride along until their stage is reached.
      if (g < L) begin : g_skew
         logic [WIDTH-1:HI+1] a_q, a_d, b_q, b_d;

         always_comb begin
            a_d = a_in[WIDTH-1:HI+1];
            b_d = b_in[WIDTH-1:HI+1];
         end

         always_ff @(posedge clk_i or negedge aresetn_i) begin
            if (!aresetn_i) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en) begin
               a_q <= a_d;
               b_q <= b_d;
            end
         end
      end
   end

   // Carry into the MSB is recovered from the MSB operand and sum bits.
   always_comb begin
      ovf_d = st[L].a_in[WIDTH-1] ^ st[L].b_in[WIDTH-1] ^ st[L].sum[CW-1] ^ st[L].sum[CW];
   end

   always_ff @(posedge clk_i or negedge aresetn_i) begin
      if (!aresetn_i) ovf_q <= 1'b0;
      else if (en)    ovf_q <= ovf_d;
   end

   assign valid_o = st[L].v_q;
   assign S_o     = st[L].s_q;
   assign Cout_o  = st[L].c_q;
   assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: 8-bit/2-stage instance plus a 1-bit/1-stage
// instance exercised as a registered full adder.
module tb_adder_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       v_i, r_o, v_o, r_i, cin, co, ov;
   logic [7:0] a, b, s;
   logic       v1_i, r1_o, v1_o, r1_i, cin1, co1, ov1;
   logic [0:0] a1, b1, s1;

   int n_tests = 0;
   int n_fail  = 0;

   adder_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
      .clk_i(clk), .aresetn_i(rst_n), .valid_i(v_i), .ready_o(r_o),
      .A_i(a), .B_i(b), .Cin_i(cin), .valid_o(v_o), .ready_i(r_i),
      .S_o(s), .Cout_o(co), .ovf_o(ov)
   );

   adder_pipe #(.WIDTH(1), .STAGES(1)) u_dut1 (
      .clk_i(clk), .aresetn_i(rst_n), .valid_i(v1_i), .ready_o(r1_o),
      .A_i(a1), .B_i(b1), .Cin_i(cin1), .valid_o(v1_o), .ready_i(r1_i),
      .S_o(s1), .Cout_o(co1), .ovf_o(ov1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run1(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic c,
                       input logic [7:0] es, input logic ec, input logic eo);
      @(negedge clk);
      r_i = 1'b1; v_i = 1'b1; a = av; b = bv; cin = c;
      @(negedge clk);
      v_i = 1'b0;
      chk({tag, "_early"}, v_o, 0);
      @(negedge clk);
      chk({tag, "_vld"}, v_o, 1);
      chk({tag, "_s"}, s, es);
      chk({tag, "_cout"}, co, ec);
      chk({tag, "_ovf"}, ov, eo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] ta [16];
   logic [7:0] tb [16];
   logic       tc [16];
   logic [9:0] exp_q [$];
   logic [9:0] hold, e;
   logic [8:0] sum9;
   logic       stall, seen;
   logic [1:0] tot;
   int         sent, got, ssum;

   initial begin
      rst_n = 1'b0;
      v_i = 0; r_i = 0; a = 0; b = 0; cin = 0;
      v1_i = 0; r1_i = 1; a1 = 0; b1 = 0; cin1 = 0;
      #12;
      chk("rst_valid", v_o, 0);
      chk("rst_s", s, 0);
      chk("rst_cout", co, 0);
      chk("rst_ovf", ov, 0);
      chk("rst_ready", r_o, 1);
      @(negedge clk);
      rst_n = 1'b1;

      run1("carry_slice", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
      run1("carry_wrap",  8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      run1("ovf_pos",     8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run1("ovf_neg",     8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      run1("alt_bits",    8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0);

      @(negedge clk);
      r_i = 1'b0;
      #1 chk("ready_idle", r_o, 1);

      // Streaming with pseudo-random backpressure and an in-order scoreboard.
      for (int i = 0; i < 16; i++) begin
         ta[i] = 8'($urandom);
         tb[i] = 8'($urandom);
         tc[i] = 1'($urandom);
      end
      sent = 0; got = 0; stall = 1'b0; hold = '0;
      for (int cyc = 0; cyc < 300 && got < 16; cyc++) begin
         @(negedge clk);
         r_i = 1'($urandom_range(0, 1));
         if (sent < 16) begin
            v_i = 1'b1; a = ta[sent]; b = tb[sent]; cin = tc[sent];
         end else begin
            v_i = 1'b0;
         end
         #1;
         if (stall) begin
            chk("hold_valid", v_o, 1);
            chk("hold_data", {ov, co, s}, hold);
         end
         if (v_o && r_i) begin
            chk("stream_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("stream_data", {ov, co, s}, e);
            end
            got++;
         end
         stall = v_o && !r_i;
         hold  = {ov, co, s};
         if (v_i && r_o) begin
            sum9 = {1'b0, ta[sent]} + {1'b0, tb[sent]} + {8'd0, tc[sent]};
            ssum = int'($signed(ta[sent])) + int'($signed(tb[sent])) + int'(tc[sent]);
            exp_q.push_back({(ssum > 127 || ssum < -128), sum9});
            sent++;
         end
      end
      chk("stream_count", got, 16);
      chk("stream_left", exp_q.size(), 0);
      @(negedge clk);
      v_i = 1'b0; r_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("drain_empty", v_o, 0);

      // Reset with two transactions in flight.
      @(negedge clk);
      r_i = 1'b1; v_i = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
      @(negedge clk);
      a = 8'h33; b = 8'h44;
      @(posedge clk);
      #2;
      v_i = 1'b0;
      chk("mid_pre_valid", v_o, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_valid", v_o, 0);
      chk("mid_s", s, 0);
      chk("mid_cout", co, 0);
      chk("mid_ready", r_o, 1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         seen = seen | v_o;
      end
      chk("mid_none_after", seen, 0);
      run1("post_rst", 8'h3C, 8'hC4, 1'b1, 8'h01, 1'b1, 1'b0);

      // 1-bit, 1-stage: full-adder truth table, one per cycle, latency 1.
      for (int i = 0; i <= 8; i++) begin
         @(negedge clk);
         if (i > 0) begin
            tot = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
            chk("fa_valid", v1_o, 1);
            chk("fa_s", s1, tot[0]);
            chk("fa_cout", co1, tot[1]);
            chk("fa_ovf", ov1, cin1 ^ tot[1]);
         end
         if (i < 8) begin
            v1_i = 1'b1;
            a1 = 1'((i >> 2) & 1); b1 = 1'((i >> 1) & 1); cin1 = 1'(i & 1);
         end else begin
            v1_i = 1'b0;
         end
      end
      @(negedge clk);
      chk("fa_idle", v1_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
